// File: rtl/hq_cal_stream.sv
// Buffers one 2xNR Alamouti channel frame, then streams the four real-valued
// effective-channel columns Hq. Define HQ_SAT_EN to saturate -(-2^(W-1)).
module hq_cal_stream #(
    parameter int W  = 16,
    parameter int NR = 2,
    localparam int IDXW = ($clog2(2*NR) < 1) ? 1 : $clog2(2*NR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_r,
    input  logic [W-1:0]    in_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    Hq_r,
    output logic [W-1:0]    Hq_i,
    output logic [1:0]      out_q,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last_col,
    output logic            out_last,
    output logic            busy
);

    localparam int NE = 2*NR;
    localparam logic [IDXW-1:0] LAST_E = IDXW'(NE-1);
    localparam logic [IDXW-1:0] NR_E   = IDXW'(NR);

    typedef enum logic {LOAD, CALC} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    buf_r [NE];
    logic [W-1:0]    buf_i [NE];
    logic [IDXW-1:0] load_cnt;
    logic            in_fire, load_done, out_fire, advance;
    logic [1:0]      sel_q;
    logic [IDXW-1:0] sel_e, oth_e;
    logic            sel_t;
    logic [W-1:0]    a_r, a_i, b_r, b_i, el_r, el_i;

    function automatic logic [W-1:0] neg(input logic [W-1:0] x);
`ifdef HQ_SAT_EN
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
`endif
        return -x;
    endfunction

    assign in_ready     = (state == LOAD);
    assign busy         = (state == CALC);
    assign in_fire      = in_valid && in_ready;
    assign load_done    = in_fire && (load_cnt == LAST_E);
    assign out_fire     = out_valid && out_ready;
    assign advance      = !out_valid || out_ready;
    assign out_last_col = out_valid && (out_idx == LAST_E);
    assign out_last     = out_last_col && (out_q == 2'd3);

    // Index of the element to present next; LOAD always starts at (q0, e0).
    always_comb begin
        sel_q = out_q;
        sel_e = out_idx + 1'b1;
        if (state == LOAD) begin
            sel_q = '0;
            sel_e = '0;
        end else if (out_idx == LAST_E) begin
            sel_q = out_q + 2'd1;
            sel_e = '0;
        end
    end

    // Buffer holds h1[0..NR-1] then h2[0..NR-1], so the partner antenna of
    // element e (h2 for t0, h1 for t1) always lives NR entries away.
    always_comb begin
        sel_t = (sel_e >= NR_E);
        oth_e = sel_t ? (sel_e - NR_E) : (sel_e + NR_E);
        a_r   = buf_r[sel_e];
        a_i   = buf_i[sel_e];
        b_r   = buf_r[oth_e];
        b_i   = buf_i[oth_e];
        el_r  = a_r;
        el_i  = a_i;
        case (sel_q)
            2'd0: begin el_r = a_r;                      el_i = a_i;                      end
            2'd1: begin el_r = sel_t ? a_i : neg(a_i);   el_i = sel_t ? neg(a_r) : a_r;   end
            2'd2: begin el_r = sel_t ? neg(b_r) : b_r;   el_i = sel_t ? neg(b_i) : b_i;   end
            default: begin el_r = neg(b_i);              el_i = b_r;                      end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_done) state_nxt = CALC;
            default: if (out_fire && out_last) state_nxt = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // NOTE: the coefficient buffer has no reset; it is always fully rewritten
    // before being read, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_r[load_cnt] <= in_r;
            buf_i[load_cnt] <= in_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            out_valid <= 1'b0;
            Hq_r      <= '0;
            Hq_i      <= '0;
            out_q     <= '0;
            out_idx   <= '0;
        end else begin
            if (in_fire)
                load_cnt <= load_done ? '0 : load_cnt + 1'b1;

            if (state == LOAD) begin
                if (load_done) begin
                    out_valid <= 1'b1;
                    Hq_r      <= el_r;
                    Hq_i      <= el_i;
                    out_q     <= sel_q;
                    out_idx   <= sel_e;
                end
            end else if (advance) begin
                if (out_valid && out_last) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    Hq_r      <= el_r;
                    Hq_i      <= el_i;
                    out_q     <= sel_q;
                    out_idx   <= sel_e;
                end
            end
        end
    end

endmodule

// File: tb/tb_hq_cal_stream.sv
// Scoreboard bench for hq_cal_stream (W=16, NR=2): directed frames with
// hand-computed Hq tables; a negedge monitor pops and compares each output.
module tb_hq_cal_stream;

    localparam int W  = 16;
    localparam int NR = 2;
`ifdef HQ_SAT_EN
    localparam int SATV = 32767;
`else
    localparam int SATV = -32768;
`endif

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_r, in_i, Hq_r, Hq_i;
    logic [1:0]    out_q;
    logic [1:0]    out_idx;
    logic          out_last_col, out_last, busy;

    hq_cal_stream #(.W(W), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .Hq_r(Hq_r), .Hq_i(Hq_i), .out_q(out_q), .out_idx(out_idx),
        .out_last_col(out_last_col), .out_last(out_last), .busy(busy)
    );

    typedef struct {
        int r; int i; int q; int idx; int lc; int l;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;   // out_ready: 0 low, 1 high, 2 pattern 1,0,0,1

    int f1_hr[4], f1_hi[4], f1_er[16], f1_ei[16];
    int f2_hr[4], f2_hi[4], f2_er[16], f2_ei[16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        int cyc = 0;
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                1:       out_ready = 1'b1;
                2:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall hold checks, in_ready low during CALC.
    initial begin
        logic stall_prev = 0;
        int   h_r = 0, h_i = 0, h_q = 0, h_e = 0, h_lc = 0, h_l = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev && out_valid) begin
                    check("hold_r",   $signed(Hq_r), h_r);
                    check("hold_i",   $signed(Hq_i), h_i);
                    check("hold_q",   out_q, h_q);
                    check("hold_idx", out_idx, h_e);
                    check("hold_flags", {out_last_col, out_last}, {h_lc[0], h_l[0]});
                end
                if (busy) check("in_ready_low_in_calc", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("Hq_r", $signed(Hq_r), e.r);
                        check("Hq_i", $signed(Hq_i), e.i);
                        check("out_q", out_q, e.q);
                        check("out_idx", out_idx, e.idx);
                        check("out_last_col", out_last_col, e.lc);
                        check("out_last", out_last, e.l);
                    end
                end
                stall_prev = out_valid && !out_ready;
                h_r  = $signed(Hq_r);
                h_i  = $signed(Hq_i);
                h_q  = out_q;
                h_e  = out_idx;
                h_lc = out_last_col;
                h_l  = out_last;
            end
        end
    end

    task automatic load_frame(input int hr[4], input int hi[4],
                              input int er[16], input int ei[16],
                              input bit gaps, input bit push);
        for (int w = 0; w < 4; w++) begin
            int n = 0;
            if (gaps && (w % 2 == 1)) begin
                in_valid = 0;
                @(posedge clk);
                #1;
            end
            in_valid = 1;
            in_r = W'(hr[w]);
            in_i = W'(hi[w]);
            @(negedge clk);
            while (!in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                $display("FAIL load_timeout: in_ready never rose (word %0d)", w);
                $fatal(1, "load timeout");
            end
            if (w == 0) check("prev_frame_drained_at_accept", sb.size(), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (push)
            for (int k = 0; k < 16; k++)
                sb.push_back('{er[k], ei[k], k / 4, k % 4, int'(k % 4 == 3), int'(k == 15)});
        check("out_valid_after_last_load", out_valid, 1);
        check("in_ready_after_last_load", in_ready, 0);
        check("busy_after_last_load", busy, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", sb.size(), 0);
        @(posedge clk);
        #1;
        check("out_valid_after_frame", out_valid, 0);
        check("in_ready_after_frame", in_ready, 1);
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
        f1_hr = '{100, 7, -32768, 3};
        f1_hi = '{-50, 8, 20, -4};
        f1_er = '{100, 7, -32768, 3,   50, -8, 20, -4,
                  -32768, 3, -100, -7, -20, 4, 50, -8};
        f1_ei = '{-50, 8, 20, -4,      100, 7, SATV, -3,
                  20, -4, 50, -8,      -32768, 3, 100, 7};
        f2_hr = '{1, 3, 5, -7};
        f2_hi = '{2, 4, 6, -8};
        f2_er = '{1, 3, 5, -7,   -2, -4, 6, -8,   5, -7, -1, -3,   -6, 8, -2, -4};
        f2_ei = '{2, 4, 6, -8,    1, 3, -5, 7,    6, -8, -2, -4,    5, -7, 1, 3};

        rst = 1; in_valid = 0; in_r = '0; in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_Hq", {Hq_r, Hq_i}, 0);
        check("rst_q_idx", {out_q, out_idx}, 0);
        check("rst_flags", {out_last_col, out_last}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);

        mode = 1;
        load_frame(f1_hr, f1_hi, f1_er, f1_ei, 0, 1);
        drain();

        mode = 2;
        load_frame(f1_hr, f1_hi, f1_er, f1_ei, 0, 1);
        drain();

        mode = 1;
        load_frame(f1_hr, f1_hi, f1_er, f1_ei, 1, 1);
        load_frame(f2_hr, f2_hi, f2_er, f2_ei, 1, 1);
        drain();

        mode = 0;
        load_frame(f2_hr, f2_hi, f2_er, f2_ei, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("midcalc_rst_out_valid", out_valid, 0);
        check("midcalc_rst_in_ready", in_ready, 1);
        check("midcalc_rst_busy", busy, 0);

        mode = 2;
        load_frame(f2_hr, f2_hi, f2_er, f2_ei, 1, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
